operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter LOAD_STALL_CYCLES, default 2: cycles a dependent instruction is held after a load leaves toward execute.
REQ-002 SHALL have ports, in this order:
- Clk  in  1  single clock; all state on posedge.
- Rst_n  in  1  asynchronous, active-low reset.
- InValid  in  1  fetch presents an instruction.
- InReady  out  1  stage accepts the instruction.
- InInstr  in  32  instruction word.
- InPC  in  32  its PC.
- Flush  in  1  discard held and incoming work.
- AddrA  out  5  register-file rs1 address.
- AddrB  out  5  register-file rs2 address.
- DataA  in  32  register-file rs1 value (combinational).
- DataB  in  32  register-file rs2 value (combinational).
- WbEn  in  1  writeback write this cycle.
- WbAddr  in  5  writeback rd.
- WbData  in  32  writeback value.
- OutValid  out  1  execute-side register holds an instruction.
- OutReady  in  1  execute consumes it.
- OutPC  out  32  registered PC.
- OutRs1Val  out  32  registered rs1 operand.
- OutRs2Val  out  32  registered rs2 operand.
- OutImm  out  32  registered sign-extended immediate.
- OutRd  out  5  registered rd.
- OutOpcode  out  7  registered opcode.
- OutFunct3  out  3  registered funct3.
- OutFunct7b5  out  1  registered InInstr[30].

Function
REQ-003 SHALL drive AddrA=InInstr[19:15], AddrB=InInstr[24:20] combinationally at all times.
REQ-004 SHALL form each operand as: 0 if address is 0; else WbData if WbEn and WbAddr equals address; else DataA/DataB.
REQ-005 SHALL generate OutImm per RV32I: I (OP_IMM, LOAD, JALR), S, B, U (LUI, AUIPC), J; 0 for OP and unknown opcodes.
REQ-006 SHALL treat rs1 as used by all opcodes except LUI, AUIPC, JAL, and rs2 as used only by OP, STORE, BRANCH.
REQ-007 SHALL transfer on InValid&&InReady: all Out* registers load in one cycle, OutValid=1 next cycle (latency 1).
REQ-008 SHALL clear OutValid on OutValid&&OutReady with no simultaneous transfer; a simultaneous transfer replaces contents (full throughput).
REQ-009 SHALL assert InReady = (!OutValid || OutReady) && !Hazard, or 1 while Flush is high.
REQ-010 SHALL raise Hazard when a used, nonzero rs equals OutRd while OutValid and OutOpcode=LOAD and OutRd!=0.
REQ-011 SHALL hold FSM states RUN and STALL: on a LOAD with rd!=0 leaving (OutValid&&OutReady), load LoadRd=OutRd, Count=LOAD_STALL_CYCLES, go STALL.
REQ-012 SHALL in STALL decrement Count each cycle, return to RUN when Count reaches 0, and raise Hazard when a used rs equals LoadRd.
REQ-013 SHALL let independent instructions pass in STALL; a new load leaving in STALL reloads LoadRd and Count.
REQ-014 SHALL on Flush: OutValid=0 next cycle, state RUN, Count=0, incoming instruction discarded; Flush overrides transfer and OutReady.
REQ-015 SHALL hold Out* data stable while OutValid&&!OutReady.

Reset
REQ-016 SHALL on Rst_n low asynchronously set OutValid=0, all Out* data=0, state RUN, Count=0, LoadRd=0; InReady=1 after release.

Structure
REQ-017 SHALL take opcode constants (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP_IMM, OP) and the RUN/STALL state encoding from shared package rv32i_pkg.
REQ-018 SHALL place immediate generation in combinational sub-module imm_gen (Instr in, Imm out).

Verification
REQ-019 Bench SHALL cover:
- ADDI x5,x0,-1 accepted, OutReady=1 -> next cycle OutValid=1, OutImm=FFFFFFFF, OutRs1Val=0.
- DataA=11111111 with WbEn=1, WbAddr=rs1, WbData=22222222 -> OutRs1Val=22222222.
- LW x3 then ADD x4,x3,x1, OutReady=1 -> ADD enters 1+LOAD_STALL_CYCLES cycles after LW leaves; ADD x4,x1,x2 instead enters with no bubble.
- OutReady=0 for 3 cycles with valid input -> InReady=0, Out* unchanged, no loss or duplication.
- Flush during STALL -> OutValid=0 next cycle, state RUN, next dependent instruction accepted immediately.
- Rst_n low mid-stall -> all outputs 0, OutValid=0 immediately, RUN after release.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode constants, operand-fetch state encoding and small decode helpers
// used by the operand fetch stage and its immediate generator.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
  } exec_bundle_t;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  // x0 reads as zero; a same-cycle writeback to the register wins over the file
  function automatic logic [31:0] bypass_operand(input logic [4:0]  addr,
                                                 input logic [31:0] rfData,
                                                 input logic        wbEn,
                                                 input logic [4:0]  wbAddr,
                                                 input logic [31:0] wbData);
    if (addr == 5'd0) begin
      return 32'd0;
    end else if (wbEn && (wbAddr == addr)) begin
      return wbData;
    end
    return rfData;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of the fetch-side handshake, register-file, writeback and execute-side
// signals around the operand fetch stage.
interface operand_fetch_if;

  logic        InValid;
  logic        InReady;
  logic [31:0] InInstr;
  logic [31:0] InPC;
  logic        Flush;
  logic [4:0]  AddrA;
  logic [4:0]  AddrB;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic        WbEn;
  logic [4:0]  WbAddr;
  logic [31:0] WbData;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutPC;
  logic [31:0] OutRs1Val;
  logic [31:0] OutRs2Val;
  logic [31:0] OutImm;
  logic [4:0]  OutRd;
  logic [6:0]  OutOpcode;
  logic [2:0]  OutFunct3;
  logic        OutFunct7b5;

  modport master (
    output InValid, InInstr, InPC, Flush, DataA, DataB, WbEn, WbAddr, WbData, OutReady,
    input  InReady, AddrA, AddrB, OutValid, OutPC, OutRs1Val, OutRs2Val, OutImm,
           OutRd, OutOpcode, OutFunct3, OutFunct7b5
  );

  modport slave (
    input  InValid, InInstr, InPC, Flush, DataA, DataB, WbEn, WbAddr, WbData, OutReady,
    output InReady, AddrA, AddrB, OutValid, OutPC, OutRs1Val, OutRs2Val, OutImm,
           OutRd, OutOpcode, OutFunct3, OutFunct7b5
  );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; formats without an immediate
// (register-register ops and unknown opcodes) produce zero.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] Instr,
  output logic [31:0] Imm
);

  always_comb begin
    Imm = 32'd0;
    case (Instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        Imm = {{20{Instr[31]}}, Instr[31:20]};
      OPC_STORE:
        Imm = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      OPC_BRANCH:
        Imm = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        Imm = {Instr[31:12], 12'd0};
      OPC_JAL:
        Imm = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      default:
        Imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads rs1/rs2 with writeback bypass, builds the immediate and
// registers the decoded instruction toward execute, holding load-dependent instructions.
module operand_fetch
  import rv32i_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] InInstr,
  input  logic [31:0] InPC,
  input  logic        Flush,
  output logic [4:0]  AddrA,
  output logic [4:0]  AddrB,
  input  logic [31:0] DataA,
  input  logic [31:0] DataB,
  input  logic        WbEn,
  input  logic [4:0]  WbAddr,
  input  logic [31:0] WbData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutPC,
  output logic [31:0] OutRs1Val,
  output logic [31:0] OutRs2Val,
  output logic [31:0] OutImm,
  output logic [4:0]  OutRd,
  output logic [6:0]  OutOpcode,
  output logic [2:0]  OutFunct3,
  output logic        OutFunct7b5
);

  localparam int CountW = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES + 1) : 1;
  localparam logic [CountW-1:0] CountInit = CountW'(LOAD_STALL_CYCLES);
  localparam logic [CountW-1:0] CountOne  = CountW'(1);

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic [31:0] rs1Val;
  logic [31:0] rs2Val;
  logic        useRs1;
  logic        useRs2;
  logic        hazOut;
  logic        hazStall;
  logic        hazard;
  logic        inReady;
  logic        transfer;
  logic        loadLeaves;

  exec_bundle_t      out_q;
  exec_bundle_t      out_d;
  logic              outValid_q;
  logic              outValid_d;
  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [CountW-1:0] count_q;
  logic [CountW-1:0] count_d;
  logic [4:0]        loadRd_q;
  logic [4:0]        loadRd_d;

  assign opcode = InInstr[6:0];
  assign rs1    = InInstr[19:15];
  assign rs2    = InInstr[24:20];
  assign AddrA  = rs1;
  assign AddrB  = rs2;

  imm_gen u_imm_gen (
    .Instr (InInstr),
    .Imm   (imm)
  );

  assign rs1Val = bypass_operand(rs1, DataA, WbEn, WbAddr, WbData);
  assign rs2Val = bypass_operand(rs2, DataB, WbEn, WbAddr, WbData);
  assign useRs1 = uses_rs1(opcode);
  assign useRs2 = uses_rs2(opcode);

  // Dependence on a load still sitting in the execute register, or one that left recently
  assign hazOut = outValid_q && (out_q.opcode == OPC_LOAD) && (out_q.rd != 5'd0) &&
                  ((useRs1 && (rs1 != 5'd0) && (rs1 == out_q.rd)) ||
                   (useRs2 && (rs2 != 5'd0) && (rs2 == out_q.rd)));
  assign hazStall = (state_q == ST_STALL) &&
                    ((useRs1 && (rs1 == loadRd_q)) || (useRs2 && (rs2 == loadRd_q)));
  assign hazard   = hazOut || hazStall;

  assign inReady    = Flush || ((!outValid_q || OutReady) && !hazard);
  assign transfer   = InValid && inReady && !Flush;
  assign loadLeaves = outValid_q && OutReady && (out_q.opcode == OPC_LOAD) &&
                      (out_q.rd != 5'd0);

  always_comb begin
    outValid_d = outValid_q;
    out_d      = out_q;
    if (Flush) begin
      outValid_d = 1'b0;
    end else if (transfer) begin
      outValid_d     = 1'b1;
      out_d.pc       = InPC;
      out_d.rs1Val   = rs1Val;
      out_d.rs2Val   = rs2Val;
      out_d.imm      = imm;
      out_d.rd       = InInstr[11:7];
      out_d.opcode   = opcode;
      out_d.funct3   = InInstr[14:12];
      out_d.funct7b5 = InInstr[30];
    end else if (outValid_q && OutReady) begin
      outValid_d = 1'b0;
    end
  end

  // A departing load restarts the hold window even if one is already running
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    loadRd_d = loadRd_q;
    if (Flush) begin
      state_d = ST_RUN;
      count_d = '0;
    end else if (loadLeaves && (LOAD_STALL_CYCLES > 0)) begin
      state_d  = ST_STALL;
      count_d  = CountInit;
      loadRd_d = out_q.rd;
    end else if (state_q == ST_STALL) begin
      if (count_q <= CountOne) begin
        state_d = ST_RUN;
        count_d = '0;
      end else begin
        count_d = count_q - CountOne;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      outValid_q <= 1'b0;
      out_q      <= '0;
    end else begin
      outValid_q <= outValid_d;
      out_q      <= out_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_RUN;
      count_q  <= '0;
      loadRd_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      loadRd_q <= loadRd_d;
    end
  end

  assign InReady     = inReady;
  assign OutValid    = outValid_q;
  assign OutPC       = out_q.pc;
  assign OutRs1Val   = out_q.rs1Val;
  assign OutRs2Val   = out_q.rs2Val;
  assign OutImm      = out_q.imm;
  assign OutRd       = out_q.rd;
  assign OutOpcode   = out_q.opcode;
  assign OutFunct3   = out_q.funct3;
  assign OutFunct7b5 = out_q.funct7b5;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a behavioural model predicts readiness and the
// registered bundle of every accepted instruction; a monitor compares what execute sees.
module tb_operand_fetch;

  localparam int N = 2;

  localparam logic [6:0] LOAD_OP   = 7'h03;
  localparam logic [6:0] STORE_OP  = 7'h23;
  localparam logic [6:0] BRANCH_OP = 7'h63;
  localparam logic [6:0] JAL_OP    = 7'h6F;
  localparam logic [6:0] JALR_OP   = 7'h67;
  localparam logic [6:0] LUI_OP    = 7'h37;
  localparam logic [6:0] AUIPC_OP  = 7'h17;
  localparam logic [6:0] IMM_OP    = 7'h13;
  localparam logic [6:0] REG_OP    = 7'h33;

  localparam logic [31:0] LW_X3    = 32'h00012183;
  localparam logic [31:0] ADD_DEP  = 32'h00118233;
  localparam logic [31:0] ADD_IND  = 32'h00208233;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  operand_fetch_if bus ();
  logic [31:0] rf [32];

  assign bus.DataA = rf[bus.AddrA];
  assign bus.DataB = rf[bus.AddrB];

  operand_fetch #(.LOAD_STALL_CYCLES(N)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .InValid     (bus.InValid),
    .InReady     (bus.InReady),
    .InInstr     (bus.InInstr),
    .InPC        (bus.InPC),
    .Flush       (bus.Flush),
    .AddrA       (bus.AddrA),
    .AddrB       (bus.AddrB),
    .DataA       (bus.DataA),
    .DataB       (bus.DataB),
    .WbEn        (bus.WbEn),
    .WbAddr      (bus.WbAddr),
    .WbData      (bus.WbData),
    .OutValid    (bus.OutValid),
    .OutReady    (bus.OutReady),
    .OutPC       (bus.OutPC),
    .OutRs1Val   (bus.OutRs1Val),
    .OutRs2Val   (bus.OutRs2Val),
    .OutImm      (bus.OutImm),
    .OutRd       (bus.OutRd),
    .OutOpcode   (bus.OutOpcode),
    .OutFunct3   (bus.OutFunct3),
    .OutFunct7b5 (bus.OutFunct7b5)
  );

  int checks = 0;
  int fails = 0;
  exp_t expQ[$];

  // Model of the execute register contents and of the post-load hold window
  bit          mValid = 1'b0;
  logic [4:0]  mOutRd = 5'd0;
  bit          mOutLoad = 1'b0;
  logic [4:0]  mHoldRd = 5'd0;
  int          mHold = 0;
  logic [31:0] pcNext = 32'h0000_1000;
  bit          lastReady = 1'b0;
  bit          lastAccept = 1'b0;

  function automatic bit usesRs1(input logic [6:0] opc);
    return !(opc == LUI_OP || opc == AUIPC_OP || opc == JAL_OP);
  endfunction

  function automatic bit usesRs2(input logic [6:0] opc);
    return (opc == REG_OP || opc == STORE_OP || opc == BRANCH_OP);
  endfunction

  function automatic bit dependsOn(input logic [31:0] instr, input logic [4:0] r);
    logic [4:0] a = instr[19:15];
    logic [4:0] b = instr[24:20];
    return (usesRs1(instr[6:0]) && a != 5'd0 && a == r) ||
           (usesRs2(instr[6:0]) && b != 5'd0 && b == r);
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    int sh = 32 - bits;
    return 32'($signed(v << sh) >>> sh);
  endfunction

  function automatic logic [31:0] immOf(input logic [31:0] instr);
    case (instr[6:0])
      IMM_OP, LOAD_OP, JALR_OP: return sext(instr >> 20, 12);
      STORE_OP:  return sext({20'd0, instr[31:25], instr[11:7]}, 12);
      BRANCH_OP: return sext({19'd0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 13);
      LUI_OP, AUIPC_OP: return instr & 32'hFFFF_F000;
      JAL_OP:    return sext({11'd0, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, 21);
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] a, input bit wbEn,
                                       input logic [4:0] wbAddr, input logic [31:0] wbData);
    if (a == 5'd0) return 32'd0;
    if (wbEn && wbAddr == a) return wbData;
    return rf[a];
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drives one cycle of stimulus, checks readiness against the model, then advances the model
  task automatic applyStimulus(input bit v, input logic [31:0] instr, input bit oready,
                               input bit flush, input bit wbEn, input logic [4:0] wbAddr,
                               input logic [31:0] wbData);
    bit   haz;
    bit   expReady;
    bit   accept;
    bit   leaving;
    exp_t e;
    bus.InValid  = v;
    bus.InInstr  = instr;
    bus.InPC     = pcNext;
    bus.OutReady = oready;
    bus.Flush    = flush;
    bus.WbEn     = wbEn;
    bus.WbAddr   = wbAddr;
    bus.WbData   = wbData;
    @(negedge Clk);
    haz = (mValid && mOutLoad && mOutRd != 5'd0 && dependsOn(instr, mOutRd)) ||
          (mHold > 0 && dependsOn(instr, mHoldRd));
    expReady = flush || ((!mValid || oready) && !haz);
    checkOutput("InReady", 160'(bus.InReady), 160'(expReady));
    checkOutput("OutValid", 160'(bus.OutValid), 160'(mValid));
    checkOutput("RfAddr", 160'({bus.AddrA, bus.AddrB}), 160'({instr[19:15], instr[24:20]}));
    lastReady = bus.InReady;
    accept = v && expReady && !flush;
    e.pc  = pcNext;
    e.rs1 = opnd(instr[19:15], wbEn, wbAddr, wbData);
    e.rs2 = opnd(instr[24:20], wbEn, wbAddr, wbData);
    e.imm = immOf(instr);
    e.rd  = instr[11:7];
    e.opc = instr[6:0];
    e.f3  = instr[14:12];
    e.f7  = instr[30];
    @(posedge Clk);
    leaving = mValid && oready && !flush;
    if (flush) begin
      mValid = 1'b0;
      mHold  = 0;
      expQ.delete();
    end else begin
      if (leaving && mOutLoad && mOutRd != 5'd0) begin
        mHoldRd = mOutRd;
        mHold   = N;
      end else if (mHold > 0) begin
        mHold--;
      end
      if (accept) begin
        mValid   = 1'b1;
        mOutRd   = instr[11:7];
        mOutLoad = (instr[6:0] == LOAD_OP);
        expQ.push_back(e);
      end else if (leaving) begin
        mValid = 1'b0;
      end
    end
    lastAccept = accept;
    pcNext = pcNext + 32'd4;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic doReset();
    Rst_n = 1'b0;
    mValid = 1'b0;
    mHold = 0;
    expQ.delete();
    #1;
    checkOutput("ResetOutValid", 160'(bus.OutValid), 160'(0));
    checkOutput("ResetOutData", 160'({bus.OutPC, bus.OutRs1Val, bus.OutRs2Val, bus.OutImm,
                bus.OutRd, bus.OutOpcode, bus.OutFunct3, bus.OutFunct7b5}), 160'(0));
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  // Presents a load, then a follower; counts cycles until the follower is taken
  task automatic loadThen(input logic [31:0] follower, input int expWait, input string nm);
    int waits = 0;
    applyStimulus(1'b1, LW_X3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, follower, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      if (lastReady) break;
      waits++;
    end
    checkOutput(nm, 160'(waits), 160'(expWait));
    checkOutput({nm, "Rd"}, 160'({bus.OutValid, bus.OutRd}), 160'({1'b1, 5'd4}));
    idle(N + 2);
  endtask

  // Scoreboard monitor: whatever execute sees must be the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge Clk);
      if (Rst_n && bus.OutValid && !bus.Flush) begin
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL OutBundle: actual=valid output required=no pending instruction at %0t", $time);
        end else begin
          checkOutput("OutBundle", 160'({bus.OutPC, bus.OutRs1Val, bus.OutRs2Val, bus.OutImm,
                      bus.OutRd, bus.OutOpcode, bus.OutFunct3, bus.OutFunct7b5}), 160'(expQ[0]));
          if (bus.OutReady) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    logic [6:0]  opcList [10] = '{LOAD_OP, STORE_OP, BRANCH_OP, JAL_OP, JALR_OP,
                                  LUI_OP, AUIPC_OP, IMM_OP, REG_OP, 7'h7F};
    logic [31:0] cur;
    bit          curValid;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    bus.InValid = 1'b0; bus.InInstr = 32'd0; bus.InPC = 32'd0; bus.Flush = 1'b0;
    bus.WbEn = 1'b0; bus.WbAddr = 5'd0; bus.WbData = 32'd0; bus.OutReady = 1'b0;

    repeat (2) @(posedge Clk);
    #1;
    checkOutput("ResetOutValid", 160'(bus.OutValid), 160'(0));
    checkOutput("ResetOutData", 160'({bus.OutPC, bus.OutRs1Val, bus.OutRs2Val, bus.OutImm,
                bus.OutRd, bus.OutOpcode, bus.OutFunct3, bus.OutFunct7b5}), 160'(0));
    Rst_n = 1'b1;
    #1;
    checkOutput("ReadyAfterReset", 160'(bus.InReady), 160'(1));

    $display("[TB] ADDI x5,x0,-1");
    applyStimulus(1'b1, 32'hFFF00293, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("AddiValid", 160'(bus.OutValid), 160'(1));
    checkOutput("AddiImm", 160'(bus.OutImm), 160'(32'hFFFF_FFFF));
    checkOutput("AddiRs1", 160'(bus.OutRs1Val), 160'(0));

    $display("[TB] writeback bypass");
    rf[7] = 32'h1111_1111;
    applyStimulus(1'b1, 32'h00038313, 1'b1, 1'b0, 1'b1, 5'd7, 32'h2222_2222);
    checkOutput("BypassRs1", 160'(bus.OutRs1Val), 160'(32'h2222_2222));
    idle(2);

    $display("[TB] load-use hold and independent follower");
    loadThen(ADD_DEP, 1 + N, "LoadUseWait");
    loadThen(ADD_IND, 0, "IndependentWait");

    $display("[TB] execute backpressure");
    applyStimulus(1'b1, 32'h00A00093, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h00508113, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("BackpressureReady", 160'(lastReady), 160'(0));
    end
    applyStimulus(1'b1, 32'h00508113, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    idle(1);
    checkOutput("NoLossNoDup", 160'(expQ.size()), 160'(0));

    $display("[TB] flush during hold");
    idle(2);
    applyStimulus(1'b1, LW_X3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, ADD_DEP, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, ADD_DEP, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    checkOutput("FlushOutValid", 160'(bus.OutValid), 160'(0));
    applyStimulus(1'b1, ADD_DEP, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("FlushThenReady", 160'(lastReady), 160'(1));
    idle(2);

    $display("[TB] reset during hold");
    applyStimulus(1'b1, LW_X3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, ADD_DEP, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    doReset();
    applyStimulus(1'b1, ADD_DEP, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("ResetThenReady", 160'(lastReady), 160'(1));
    idle(2);

    $display("[TB] randomized traffic");
    cur = 32'd0;
    curValid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (lastAccept || !curValid || bus.Flush) begin
        cur = $urandom;
        cur[6:0]   = opcList[$urandom_range(0, 9)];
        cur[11:7]  = 5'($urandom_range(0, 3));
        cur[19:15] = 5'($urandom_range(0, 3));
        cur[24:20] = 5'($urandom_range(0, 3));
        curValid = ($urandom_range(0, 9) < 8);
      end
      applyStimulus(curValid, cur, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
    end
    idle(N + 3);
    checkOutput("DrainedEmpty", 160'(expQ.size()), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
